// File: rtl/prog_clock_div_if.sv
// Configuration write port of prog_clock_div.
// Carries a valid/ready write of period and high time, plus a one-cycle reject pulse.
interface prog_clock_div_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 27
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_high,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_high,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/prog_clock_div.sv
// Multi-channel runtime-programmable clock divider and tick generator.
// Writes land in a per-channel shadow and reach the active registers at the period wrap, or at once while disabled.
//
// state  | meaning
// ST_OFF | disabled or fresh out of reset; the next enabled edge holds cnt at 0 and starts a period
// ST_RUN | counting through the active period
module prog_clock_div #(
  parameter int CHANNELS     = 4,
  parameter int CH_W         = 2,
  parameter int CNT_W        = 27,
  parameter int DEFAULT_DIV  = 100_000_000,
  parameter int DEFAULT_HIGH = DEFAULT_DIV / 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ch_en,
  prog_clock_div_if.slave     cfg,
  output logic [CHANNELS-1:0] hz_out,
  output logic [CHANNELS-1:0] tick
);
  typedef enum logic {ST_OFF, ST_RUN} ch_state_t;

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);
  localparam int               SEL_N    = 2 ** CH_W;

  ch_state_t        state    [CHANNELS];
  logic [CNT_W-1:0] cnt      [CHANNELS];
  logic [CNT_W-1:0] div_act  [CHANNELS];
  logic [CNT_W-1:0] high_act [CHANNELS];
  logic [CNT_W-1:0] div_shd  [CHANNELS];
  logic [CNT_W-1:0] high_shd [CHANNELS];
  logic [CNT_W-1:0] cnt_nxt  [CHANNELS];
  logic [CNT_W-1:0] div_nxt  [CHANNELS];
  logic [CNT_W-1:0] high_nxt [CHANNELS];

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] apply;
  logic [SEL_N-1:0]    pend_sel;
  logic                cfg_acc;
  logic                ch_bad;
  logic                div_bad;
  logic                cfg_ok;

  // Unused channel codes read as never pending, so writes to them are accepted and rejected.
  always_comb begin
    pend_sel                = '0;
    pend_sel[CHANNELS-1:0]  = pending;
  end

  assign cfg.cfg_ready = ~pend_sel[cfg.cfg_ch];
  assign cfg_acc       = cfg.cfg_valid & cfg.cfg_ready;
  assign ch_bad        = {1'b0, cfg.cfg_ch} >= (CH_W + 1)'(CHANNELS);
  assign div_bad       = cfg.cfg_div < CNT_W'(2);
  assign cfg_ok        = cfg_acc & ~ch_bad & ~div_bad;

  // A disabled channel applies its shadow on any edge; a running one only on the wrap.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = '0;
      apply[i]   = pending[i];
      if (ch_en[i] && state[i] == ST_RUN) begin
        if (cnt[i] != div_act[i] - CNT_W'(1)) begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
        apply[i] = pending[i] && (cnt_nxt[i] == '0);
      end
      div_nxt[i]  = apply[i] ? div_shd[i]  : div_act[i];
      high_nxt[i] = apply[i] ? high_shd[i] : high_act[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]    <= ST_OFF;
        cnt[i]      <= '0;
        div_act[i]  <= DEF_DIV;
        high_act[i] <= DEF_HIGH;
        div_shd[i]  <= '0;
        high_shd[i] <= '0;
      end
      pending     <= '0;
      hz_out      <= '0;
      tick        <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg_acc & (ch_bad | div_bad);
      for (int i = 0; i < CHANNELS; i++) begin
        if (apply[i]) begin
          div_act[i]  <= div_shd[i];
          high_act[i] <= high_shd[i];
          pending[i]  <= 1'b0;
        end
        // Never coincides with apply: a write is only accepted while nothing is pending.
        if (cfg_ok && cfg.cfg_ch == CH_W'(i)) begin
          div_shd[i]  <= cfg.cfg_div;
          high_shd[i] <= cfg.cfg_high;
          pending[i]  <= 1'b1;
        end
        if (ch_en[i]) begin
          state[i]  <= ST_RUN;
          cnt[i]    <= cnt_nxt[i];
          hz_out[i] <= cnt_nxt[i] < high_nxt[i];
          tick[i]   <= cnt_nxt[i] == div_nxt[i] - CNT_W'(1);
        end else begin
          state[i]  <= ST_OFF;
          cnt[i]    <= '0;
          hz_out[i] <= 1'b0;
          tick[i]   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_clock_div.sv
// Directed bench for prog_clock_div: per-cycle scoreboard against a behavioural model,
// plus period/high-time measurements checked against hand-derived constants.
module tb_prog_clock_div;
  localparam int CH    = 3;
  localparam int CHW   = 2;
  localparam int CW    = 8;
  localparam int DDIV  = 10;
  localparam int DHIGH = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] hz_out;
  logic [CH-1:0] tick;

  prog_clock_div_if #(.CH_W(CHW), .CNT_W(CW)) cfg ();

  prog_clock_div #(
    .CHANNELS(CH), .CH_W(CHW), .CNT_W(CW), .DEFAULT_DIV(DDIV), .DEFAULT_HIGH(DHIGH)
  ) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .cfg(cfg), .hz_out(hz_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int m_cnt[CH], m_div[CH], m_high[CH], m_sdiv[CH], m_shigh[CH];
  bit m_pend[CH], m_run[CH];
  logic [2*CH:0] sb[$];

  int            hi_cnt[CH], tk_cnt[CH];
  logic [CH-1:0] first_hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(int ch);
    if (ch >= CH) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_div[i] = DDIV; m_high[i] = DHIGH;
      m_sdiv[i] = 0; m_shigh[i] = 0; m_pend[i] = 0; m_run[i] = 0;
    end
    sb.delete();
  endtask

  // Model of one clock edge; returns the expected {cfg_err, tick, hz_out} after it.
  task automatic model_edge(output logic [2*CH:0] e);
    int            tgt;
    bit            acc, bad;
    logic [CH-1:0] ehz, etk;
    tgt = int'(cfg.cfg_ch);
    acc = cfg.cfg_valid && model_ready(tgt);
    bad = (tgt >= CH) || (int'(cfg.cfg_div) < 2);
    for (int i = 0; i < CH; i++) begin
      int nxt;
      ehz[i] = 1'b0;
      etk[i] = 1'b0;
      if (!ch_en[i]) begin
        if (m_pend[i]) begin
          m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
        end
        m_cnt[i] = 0;
        m_run[i] = 0;
      end else begin
        if (!m_run[i]) nxt = 0;
        else nxt = (m_cnt[i] == m_div[i] - 1) ? 0 : m_cnt[i] + 1;
        m_run[i] = 1;
        if (nxt == 0 && m_pend[i]) begin
          m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
        end
        m_cnt[i] = nxt;
        ehz[i]   = nxt < m_high[i];
        etk[i]   = nxt == m_div[i] - 1;
      end
    end
    if (acc && !bad) begin
      m_sdiv[tgt]  = int'(cfg.cfg_div);
      m_shigh[tgt] = int'(cfg.cfg_high);
      m_pend[tgt]  = 1;
    end
    e = {acc && bad, etk, ehz};
  endtask

  // Entered and left at posedge+1.
  task automatic step();
    logic [2*CH:0] e, got;
    #1;
    chk("cfg_ready", 32'(cfg.cfg_ready), 32'(model_ready(int'(cfg.cfg_ch))));
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {cfg.cfg_err, tick, hz_out};
    e = sb.pop_front();
    chk("outputs{err,tick,hz}", 32'(got), 32'(e));
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < CH; i++) begin
      hi_cnt[i] = 0; tk_cnt[i] = 0;
    end
    for (int k = 0; k < n; k++) begin
      step();
      if (k == 0) first_hz = hz_out;
      for (int i = 0; i < CH; i++) begin
        hi_cnt[i] += int'(hz_out[i]);
        tk_cnt[i] += int'(tick[i]);
      end
    end
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hg);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = CHW'(ch);
    cfg.cfg_div   = CW'(dv);
    cfg.cfg_high  = CW'(hg);
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_applied(input int ch);
    cfg.cfg_ch = CHW'(ch);
    for (int k = 0; k < 40 && !cfg.cfg_ready; k++) step();
    chk("apply_wait", 32'(cfg.cfg_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    ch_en         = '1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_div   = '0;
    cfg.cfg_high  = '0;

    @(posedge clk);
    #1;
    chk("reset_hz", 32'(hz_out), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_err", 32'(cfg.cfg_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Defaults: period 10, 5 high, on every channel
    measure(20);
    for (int i = 0; i < CH; i++) begin
      chk("default_high", hi_cnt[i], 10);
      chk("default_ticks", tk_cnt[i], 2);
    end

    // Reprogram ch1 to 6/2 while its cnt is 3
    for (int k = 0; k < 20 && !tick[1]; k++) step();
    chk("ch1_tick_seen", 32'(tick[1]), 1);
    repeat (4) step();
    cfg_write(1, 6, 2);
    chk("ch1_ready_pending", 32'(cfg.cfg_ready), 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[1] && n < 20);
    chk("ch1_old_period_end", n, 5);
    step();
    chk("ch1_ready_after_wrap", 32'(cfg.cfg_ready), 1);
    measure(12);
    chk("ch1_new_high", hi_cnt[1], 4);
    chk("ch1_new_ticks", tk_cnt[1], 2);

    // Rejected writes
    cfg_write(0, 1, 3);
    chk("err_div1", 32'(cfg.cfg_err), 1);
    step();
    chk("err_one_cycle", 32'(cfg.cfg_err), 0);
    cfg_write(2, 0, 3);
    chk("err_div0", 32'(cfg.cfg_err), 1);
    cfg_write(3, 5, 2);
    chk("err_bad_ch", 32'(cfg.cfg_err), 1);
    step();
    measure(20);
    chk("after_err_ch0_high", hi_cnt[0], 10);
    chk("after_err_ch0_ticks", tk_cnt[0], 2);
    chk("after_err_ch2_high", hi_cnt[2], 10);

    // Edge high values on ch0
    cfg_write(0, 4, 0);
    wait_applied(0);
    measure(8);
    chk("high0_high", hi_cnt[0], 0);
    chk("high0_ticks", tk_cnt[0], 2);
    cfg_write(0, 8, 12);
    wait_applied(0);
    measure(16);
    chk("high12_high", hi_cnt[0], 16);
    chk("high12_ticks", tk_cnt[0], 2);

    // Disable ch2 at cnt 4 for 3 cycles, reprogramming it while off
    for (int k = 0; k < 20 && !tick[2]; k++) step();
    chk("ch2_tick_seen", 32'(tick[2]), 1);
    repeat (5) step();
    ch_en[2] = 1'b0;
    step();
    chk("ch2_off_1", 32'(hz_out[2]), 0);
    cfg_write(2, 5, 3);
    chk("ch2_off_2", 32'(hz_out[2]), 0);
    step();
    chk("ch2_off_3", 32'(hz_out[2]), 0);
    ch_en[2] = 1'b1;
    measure(10);
    chk("ch2_reen_first_hz", 32'(first_hz[2]), 1);
    chk("ch2_reen_high", hi_cnt[2], 6);
    chk("ch2_reen_ticks", tk_cnt[2], 2);

    // Asynchronous reset between edges with ch1 pending
    cfg_write(1, 9, 4);
    chk("pre_reset_hz0", 32'(hz_out[0]), 1);
    chk("pre_reset_ready", 32'(cfg.cfg_ready), 0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_hz", 32'(hz_out), 0);
    chk("async_reset_tick", 32'(tick), 0);
    chk("async_reset_err", 32'(cfg.cfg_err), 0);
    chk("async_reset_ready", 32'(cfg.cfg_ready), 1);
    #2;
    reset = 1'b0;
    model_reset();
    measure(20);
    chk("post_reset_ch0_high", hi_cnt[0], 10);
    chk("post_reset_ch1_high", hi_cnt[1], 10);
    chk("post_reset_ch1_ticks", tk_cnt[1], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
